v_hier_collect: RTL and testbench

- Receive-side counterpart of the nibble producer in the v_hier hierarchy.
- Accepts 4-bit nibbles (the producer's qvec stream) over a valid/ready handshake.
- Packs nibbles LSB-first into NIBS-nibble words and buffers completed words in a DEPTH-entry FIFO toward a word consumer.
- Gives the hierarchy tests a sequential leaf with real backpressure.

---
 rtl/v_hier_collect.sv | 167 ++++++++++++++++
 tb/tb_v_hier_collect.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_hier_collect.sv
// Nibble collector: packs 4-bit nibbles LSB-first into NIBS-nibble words and
// queues finished words in a small circular FIFO toward a word consumer.
module v_hier_collect #(
  parameter int NIBS  = 4,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(NIBS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_nib,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NIBS-1:0]   out_word,
  output logic [CW-1:0]       out_count,
  output logic                out_partial,
  output logic [7:0]          drop_cnt
);

  localparam int WW = 4 * NIBS;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] nib_cnt_q, nib_cnt_d;
  logic [WW-1:0] shift_q, shift_d;

  logic [WW-1:0] mem_word_q    [DEPTH];
  logic [CW-1:0] mem_count_q   [DEPTH];
  logic          mem_partial_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  logic [WW-1:0] hold_word_q;
  logic [CW-1:0] hold_count_q;
  logic          hold_partial_q;

  logic [7:0]    drop_q, drop_d;

  logic          fifo_full, fifo_empty;
  logic          accept, pop, push;
  logic [CW-1:0] cnt_inc;
  logic [WW-1:0] merged;
  logic          push_partial;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_full  = (occ_q == OW'(DEPTH));
  assign fifo_empty = (occ_q == '0);

  // in_ready depends only on registered occupancy, so a pop frees space one edge later
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;

  assign accept  = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign cnt_inc = nib_cnt_q + CW'(1);

  always_comb begin
    merged = shift_q;
    for (int s = 0; s < NIBS; s++) begin
      if (nib_cnt_q == CW'(s)) merged[4*s +: 4] = in_nib;
    end
  end

  assign push         = accept && ((cnt_inc == CW'(NIBS)) || in_last);
  assign push_partial = in_last && (cnt_inc != CW'(NIBS));

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE, FILL: begin
        if (push) begin
          state_d   = IDLE;
          nib_cnt_d = '0;
          shift_d   = '0;
        end else if (accept) begin
          state_d   = FILL;
          nib_cnt_d = cnt_inc;
          shift_d   = merged;
        end
      end
      default: begin
        state_d   = IDLE;
        nib_cnt_d = '0;
        shift_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? nextPtr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? nextPtr(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + OW'(1);
    else if (pop && !push) occ_d = occ_q - OW'(1);
  end

  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      nib_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_word_q[i]    <= '0;
        mem_count_q[i]   <= '0;
        mem_partial_q[i] <= 1'b0;
      end
    end else if (push) begin
      mem_word_q[wr_ptr_q]    <= merged;
      mem_count_q[wr_ptr_q]   <= cnt_inc;
      mem_partial_q[wr_ptr_q] <= push_partial;
    end
  end

  // Snapshot of the head so the data outputs keep their last value once the FIFO drains
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_word_q    <= '0;
      hold_count_q   <= '0;
      hold_partial_q <= 1'b0;
    end else if (!fifo_empty) begin
      hold_word_q    <= mem_word_q[rd_ptr_q];
      hold_count_q   <= mem_count_q[rd_ptr_q];
      hold_partial_q <= mem_partial_q[rd_ptr_q];
    end
  end

  assign out_word    = fifo_empty ? hold_word_q    : mem_word_q[rd_ptr_q];
  assign out_count   = fifo_empty ? hold_count_q   : mem_count_q[rd_ptr_q];
  assign out_partial = fifo_empty ? hold_partial_q : mem_partial_q[rd_ptr_q];
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_v_hier_collect.sv
// Self-checking bench for v_hier_collect: directed scenarios plus a randomized
// run compared against a queue-based model of words and pending nibbles.
module tb_v_hier_collect;

  localparam int NIBS  = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(NIBS + 1);
  localparam int WW    = 4 * NIBS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_nib = 4'h0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_word;
  logic [CW-1:0] out_count;
  logic          out_partial;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [WW-1:0] word;
    int            count;
    bit            partial;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] pend[$];
  ent_t       shown;
  int         mdrop;

  v_hier_collect #(.NIBS(NIBS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_count(out_count), .out_partial(out_partial), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    pend.delete();
    shown.word = '0;
    shown.count = 0;
    shown.partial = 1'b0;
    mdrop = 0;
  endfunction

  // One clock edge of the reference behaviour: words are whole queue entries
  function automatic void model_clock(bit v, logic [3:0] n, bit l, bit r);
    bit   rdy;
    ent_t e;
    rdy = (mq.size() < DEPTH);
    if (v && !rdy && mdrop < 255) mdrop++;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v && rdy) begin
      pend.push_back(n);
      if (pend.size() == NIBS || l) begin
        e.word = '0;
        for (int i = 0; i < pend.size(); i++) e.word |= WW'(pend[i]) << (4 * i);
        e.count = pend.size();
        e.partial = l && (pend.size() < NIBS);
        mq.push_back(e);
        pend.delete();
      end
    end
    if (mq.size() > 0) shown = mq[0];
  endfunction

  task automatic cycle(input bit v, input logic [3:0] n, input bit l, input bit r);
    in_valid = v; in_nib = n; in_last = l; out_ready = r;
    @(posedge clk);
    model_clock(v, n, l, r);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    do_reset();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h want=0", out_valid); end
    total++; if (out_word !== '0) begin bad++; $display("[TB] FAIL reset_word got=%0h want=0", out_word); end
    total++; if (out_count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0h want=0", out_count); end
    total++; if (out_partial !== 1'b0) begin bad++; $display("[TB] FAIL reset_partial got=%0h want=0", out_partial); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop got=%0d want=0", drop_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0h want=1", in_ready); end
  endtask

  task automatic test_full_word();
    cycle(1, 4'h1, 0, 1);
    cycle(1, 4'h2, 0, 1);
    cycle(1, 4'h3, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_early got=%0h want=0", out_valid); end
    cycle(1, 4'h4, 0, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_valid got=%0h want=1", out_valid); end
    total++; if (out_word !== 16'h4321) begin bad++; $display("[TB] FAIL full_word got=%0h want=4321", out_word); end
    total++; if (out_count !== CW'(4)) begin bad++; $display("[TB] FAIL full_count got=%0d want=4", out_count); end
    total++; if (out_partial !== 1'b0) begin bad++; $display("[TB] FAIL full_partial got=%0h want=0", out_partial); end
    cycle(0, 4'h0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_popped got=%0h want=0", out_valid); end
    total++; if (out_word !== 16'h4321) begin bad++; $display("[TB] FAIL full_hold got=%0h want=4321", out_word); end
  endtask

  task automatic test_partial();
    cycle(1, 4'hA, 0, 0);
    cycle(1, 4'hB, 1, 0);
    total++; if (out_word !== 16'h00BA) begin bad++; $display("[TB] FAIL part_word got=%0h want=00ba", out_word); end
    total++; if (out_count !== CW'(2)) begin bad++; $display("[TB] FAIL part_count got=%0d want=2", out_count); end
    total++; if (out_partial !== 1'b1) begin bad++; $display("[TB] FAIL part_flag got=%0h want=1", out_partial); end
    cycle(0, 4'h0, 0, 1);
    cycle(1, 4'hC, 0, 0);
    cycle(1, 4'hD, 0, 0);
    cycle(1, 4'hE, 0, 0);
    cycle(1, 4'hF, 0, 0);
    total++; if (out_word !== 16'hFEDC) begin bad++; $display("[TB] FAIL part_next got=%0h want=fedc", out_word); end
    total++; if (out_partial !== 1'b0) begin bad++; $display("[TB] FAIL part_next_flag got=%0h want=0", out_partial); end
    cycle(1, 4'h7, 1, 1);
    cycle(0, 4'h0, 0, 1);
    total++; if (out_word !== 16'h0007 || out_count !== CW'(1) || out_partial !== 1'b1) begin
      bad++; $display("[TB] FAIL part_single got=%0h/%0d/%0h want=0007/1/1", out_word, out_count, out_partial);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      total++;
      if (in_ready !== (i < 8)) begin bad++; $display("[TB] FAIL bp_ready[%0d] got=%0h want=%0h", i, in_ready, (i < 8)); end
      cycle(1, 4'((i % 15) + 1), 0, 0);
    end
    total++; if (drop_cnt !== 8'd4) begin bad++; $display("[TB] FAIL bp_drop got=%0d want=4", drop_cnt); end
    total++; if (out_word !== 16'h4321) begin bad++; $display("[TB] FAIL bp_head1 got=%0h want=4321", out_word); end
    cycle(0, 4'h0, 0, 1);
    total++; if (out_word !== 16'h8765) begin bad++; $display("[TB] FAIL bp_head2 got=%0h want=8765", out_word); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_back got=%0h want=1", in_ready); end
    cycle(0, 4'h0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained got=%0h want=0", out_valid); end
  endtask

  task automatic test_push_pop();
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 4'(i), 0, 0);
    cycle(0, 4'h0, 0, 1);
    total++; if (out_word !== 16'h8765) begin bad++; $display("[TB] FAIL pp_head got=%0h want=8765", out_word); end
    cycle(1, 4'h9, 0, 0);
    cycle(1, 4'hA, 0, 0);
    cycle(1, 4'hB, 0, 0);
    cycle(1, 4'hC, 0, 1);
    total++; if (out_valid !== 1'b1 || out_word !== 16'hCBA9) begin
      bad++; $display("[TB] FAIL pp_wrap got=%0h/%0h want=1/cba9", out_valid, out_word);
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL pp_occ got=%0h want=1", in_ready); end
    cycle(0, 4'h0, 0, 1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL pp_drained got=%0h want=0", out_valid); end
  endtask

  task automatic test_reset_mid_word();
    cycle(1, 4'h1, 0, 1);
    cycle(1, 4'h2, 0, 1);
    cycle(1, 4'h3, 0, 1);
    do_reset();
    total++; if (out_valid !== 1'b0 || out_word !== '0 || out_count !== '0 || out_partial !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_reset got=%0h/%0h/%0d/%0h want=0/0/0/0", out_valid, out_word, out_count, out_partial);
    end
    cycle(1, 4'h5, 0, 0);
    cycle(1, 4'h6, 0, 0);
    cycle(1, 4'h7, 0, 0);
    cycle(1, 4'h8, 0, 0);
    total++; if (out_word !== 16'h8765 || out_count !== CW'(4)) begin
      bad++; $display("[TB] FAIL mid_next got=%0h/%0d want=8765/4", out_word, out_count);
    end
    cycle(0, 4'h0, 0, 1);
  endtask

  task automatic test_drop_sat();
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 4'h3, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 4'h3, 0, 0);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("[TB] FAIL drop_sat got=%0d want=255", drop_cnt); end
  endtask

  task automatic test_random();
    bit v, l, r;
    logic [3:0] n;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        l = ($urandom_range(0, 5) == 0);
        r = ($urandom_range(0, 2) != 0);
        n = 4'($urandom);
        total++;
        if (in_ready !== (mq.size() < DEPTH)) begin
          bad++; $display("[TB] FAIL rnd_ready[%0d] got=%0h want=%0h", c, in_ready, (mq.size() < DEPTH));
        end
        cycle(v, n, l, r);
      end
      total++;
      if (out_valid !== (mq.size() > 0)) begin
        bad++; $display("[TB] FAIL rnd_valid[%0d] got=%0h want=%0h", c, out_valid, (mq.size() > 0));
      end
      total++;
      if (out_word !== shown.word || out_count !== CW'(shown.count) || out_partial !== shown.partial) begin
        bad++;
        $display("[TB] FAIL rnd_data[%0d] got=%0h/%0d/%0h want=%0h/%0d/%0h", c, out_word, out_count,
                 out_partial, shown.word, shown.count, shown.partial);
      end
      total++;
      if (drop_cnt !== 8'(mdrop)) begin bad++; $display("[TB] FAIL rnd_drop[%0d] got=%0d want=%0d", c, drop_cnt, mdrop); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_push_pop();
    test_reset_mid_word();
    test_drop_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
